// File: rtl/bram_pkg.sv
// Shared encodings for the dual-port block RAM: read-during-write modes and
// the power-up clear FSM states.
package bram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/bram_clear_ctrl.sv
// Clear sequencer: after reset walks every address once writing zero, then
// parks in IDLE until the next reset. State is exported for observation.
module bram_clear_ctrl
  import bram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we,
  output logic              state
);

  clr_state_t        st, st_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st  <= CLEAR;
      cnt <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
    end
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    busy   = 1'b0;
    clr_we = 1'b0;
    case (st)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_nx = cnt + 1'b1;
        // The last address has just been zeroed; the wrapped counter is unused.
        if (cnt == {ADDR_W{1'b1}}) st_nx = IDLE;
      end
      IDLE: begin
        st_nx = IDLE;
      end
      default: begin
        st_nx = CLEAR;
      end
    endcase
  end

  assign clr_addr = cnt;
  assign state    = st;

endmodule

// File: rtl/bram_sync_dp.sv
// Single-clock true dual-port RAM with byte enables and power-up clear.
// Define BRAM_OUT_REG_EN to add a second output register (read latency 2).
module bram_sync_dp
  import bram_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 4,
  parameter int RAM_BYTE_WIDTH = 8,
  parameter int RD_MODE        = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     a_wr,
  input  logic                                     b_wr,
  input  logic [RAM_DATA_WIDTH/RAM_BYTE_WIDTH-1:0] a_be,
  input  logic [RAM_DATA_WIDTH/RAM_BYTE_WIDTH-1:0] b_be,
  input  logic [RAM_ADDR_WIDTH-1:0]                a_addr,
  input  logic [RAM_ADDR_WIDTH-1:0]                b_addr,
  input  logic [RAM_DATA_WIDTH-1:0]                a_data_in,
  input  logic [RAM_DATA_WIDTH-1:0]                b_data_in,
  output logic [RAM_DATA_WIDTH-1:0]                a_data_out,
  output logic [RAM_DATA_WIDTH-1:0]                b_data_out,
  output logic                                     busy
);

  localparam int NBE   = RAM_DATA_WIDTH / RAM_BYTE_WIDTH;
  localparam int DEPTH = 1 << RAM_ADDR_WIDTH;

  logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];
  logic [RAM_ADDR_WIDTH-1:0] clr_addr;
  logic                      clr_we;
  logic                      clr_state;
  logic                      rd_en;
  logic                      a_wr_en, b_wr_en;
  logic [RAM_DATA_WIDTH-1:0] a_rd_word, b_rd_word;
  logic [RAM_DATA_WIDTH-1:0] a_q, b_q;

  bram_clear_ctrl #(.ADDR_W(RAM_ADDR_WIDTH)) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we),
    .state    (clr_state)
  );

  assign rd_en   = (clr_state == IDLE);
  assign a_wr_en = a_wr && rd_en;
  assign b_wr_en = b_wr && rd_en;

  // Port B lanes are issued first so an overlapping port A lane overrides them.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int l = 0; l < NBE; l++) begin
        if (b_wr_en && b_be[l])
          mem[b_addr][l*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH] <= b_data_in[l*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH];
      end
      for (int l = 0; l < NBE; l++) begin
        if (a_wr_en && a_be[l])
          mem[a_addr][l*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH] <= a_data_in[l*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH];
      end
    end
  end

  // Write-first merges only the port's own write lanes; the other port's
  // same-cycle write is never visible, so cross-port reads stay old-data.
  always_comb begin
    a_rd_word = mem[a_addr];
    b_rd_word = mem[b_addr];
    if (RD_MODE == WR_FIRST) begin
      for (int l = 0; l < NBE; l++) begin
        if (a_wr_en && a_be[l])
          a_rd_word[l*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH] = a_data_in[l*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH];
        if (b_wr_en && b_be[l])
          b_rd_word[l*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH] = b_data_in[l*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !rd_en) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_rd_word;
      b_q <= b_rd_word;
    end
  end

`ifdef BRAM_OUT_REG_EN
  logic [RAM_DATA_WIDTH-1:0] a_q2, b_q2;

  always_ff @(posedge clk) begin
    if (!rst || !rd_en) begin
      a_q2 <= '0;
      b_q2 <= '0;
    end else begin
      a_q2 <= a_q;
      b_q2 <= b_q;
    end
  end

  assign a_data_out = a_q2;
  assign b_data_out = b_q2;
`else
  assign a_data_out = a_q;
  assign b_data_out = b_q;
`endif

endmodule

// File: doc/bram_sync_dp.md
BRAM_SYNC_DP -- requirements
Module: bram_sync_dp

Interface
REQ-001 SHALL have parameter RAM_DATA_WIDTH, default 8, word width in bits (multiple of RAM_BYTE_WIDTH).
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 4, address width; depth = 2**RAM_ADDR_WIDTH.
REQ-003 SHALL have parameter RAM_BYTE_WIDTH, default 8, bits per byte-enable lane; NBE = RAM_DATA_WIDTH/RAM_BYTE_WIDTH.
REQ-004 SHALL have parameter RD_MODE, default 0, read-during-write on same port: 0 read-first (old data), 1 write-first (new data).
REQ-005 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 a_wr / b_wr  in  1  per-port write strobe.
REQ-008 a_be / b_be  in  NBE  per-port byte enables, lane i covers bits [i*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH].
REQ-009 a_addr / b_addr  in  RAM_ADDR_WIDTH  per-port address.
REQ-010 a_data_in / b_data_in  in  RAM_DATA_WIDTH  per-port write data.
REQ-011 a_data_out / b_data_out  out  RAM_DATA_WIDTH  per-port read data.
REQ-012 busy  out  1  high while memory clear in progress; port accesses ignored.

Function
REQ-013 Each port SHALL read every cycle busy=0; a_data_out/b_data_out valid 1 cycle after address (2 with BRAM_OUT_REG_EN).
REQ-014 Write SHALL update only lanes with be=1; wr=1 with be=0 SHALL leave memory unchanged.
REQ-015 Same-port read-during-write SHALL return old word (RD_MODE=0) or merged new word (RD_MODE=1).
REQ-016 Cross-port read of address written same cycle by other port SHALL return old word regardless of RD_MODE.
REQ-017 Both ports writing same address same cycle: port A lanes SHALL win per overlapping lane; non-overlapping lanes from B SHALL be written.
REQ-018 Clear FSM states: CLEAR, IDLE; CLEAR writes zero to address cnt, cnt increments 0..2**RAM_ADDR_WIDTH-1, then IDLE.
REQ-019 CLEAR SHALL take exactly 2**RAM_ADDR_WIDTH cycles after rst deasserts; busy=1 in CLEAR, 0 in IDLE.
REQ-020 While busy=1, a_wr/b_wr SHALL be ignored and data outputs SHALL hold 0.
REQ-021 Counter wrap at last address SHALL transition to IDLE, never re-clear without reset.

Reset
REQ-022 rst=0 on a clock edge SHALL force: FSM=CLEAR, cnt=0, busy=1, a_data_out=0, b_data_out=0, output pipeline registers=0.
REQ-023 rst=0 mid-clear or mid-operation SHALL restart clear from address 0; no partial state retained.

Configuration
REQ-024 Macro BRAM_OUT_REG_EN defined: extra output register per port, read latency 2, register reset to 0 and held 0 while busy.
REQ-025 Macro BRAM_OUT_REG_EN undefined: read latency 1, no extra register; all other behaviour identical.

Structure
REQ-026 Shared package bram_pkg SHALL hold RD_MODE encodings (RD_FIRST=0, WR_FIRST=1) and clear FSM state encoding.
REQ-027 Clear FSM and counter SHALL be sub-module bram_clear_ctrl (outputs busy, clr_addr, clr_we); memory array and port logic in bram_sync_dp.

Verification (defaults, depth 16, latency 1 unless noted)
REQ-028 rst=0 2 cycles then 1 -> busy=1 for exactly 16 cycles then 0; every address reads 0x00.
REQ-029 A writes 0xA5 to addr 3, be=1; next cycle B reads addr 3 -> b_data_out=0xA5 one cycle later.
REQ-030 addr 5 holds 0x11; A writes 0x22 to addr 5 with read -> a_data_out=0x11 (RD_MODE=0) / 0x22 (RD_MODE=1); B same-cycle read -> 0x11.
REQ-031 RAM_DATA_WIDTH=16: addr 2=0x0000; A writes 0xAABB be=01, B writes 0xCCDD be=11 same cycle -> addr 2=0xCCBB.
REQ-032 rst=0 at clear cycle 7, then 1 -> busy high 16 further cycles; A write during busy to addr 0 discarded, reads 0.
REQ-033 BRAM_OUT_REG_EN defined: A reads addr 3 (0xA5) -> a_data_out=0xA5 exactly 2 cycles after address.
